// File: rtl/rsa_core_arbiter.sv
// rsa_core_arbiter: round-robin sharing of one rsa_rfid modexp core among N_REQ channels,
// with operand capture, go/done handshake, result return and a watchdog for a hung core.
module rsa_core_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned TO_W  = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_text,
  input  logic [N_REQ*W-1:0] req_key,
  input  logic [N_REQ*W-1:0] req_mod,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_text,
  output logic               rsp_err,
  output logic               busy,
  output logic               core_reset,
  output logic [W-1:0]       core_input_text,
  output logic [W-1:0]       core_key,
  output logic [W-1:0]       core_mod,
  output logic               core_go,
  input  logic               core_done,
  input  logic [W-1:0]       core_output_text
);

  localparam int unsigned SelW = $clog2(N_REQ);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StResp, StFlush} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, rr_ptr_q;
  logic [SelW-1:0] grant_idx, cand;
  logic            grant_found;
  logic            armed_q;
  logic [TO_W-1:0] wd_q;
  logic            wd_term;
  logic [1:0]      flush_cnt_q;
  logic [W-1:0]    res_q;

  assign wd_term = (wd_q == {TO_W{1'b1}});

  // Scan starts just after the last grant, so the previous winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = SelW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_found) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait: begin
        // done beats a simultaneous watchdog terminal count
        if (armed_q && core_done) state_d = StResp;
        else if (wd_term)         state_d = StFlush;
      end
      StResp:   state_d = StIdle;
      StFlush:  if (flush_cnt_q == 2'd2) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q           <= '0;
      rr_ptr_q        <= SelW'(N_REQ - 1);
      armed_q         <= 1'b0;
      wd_q            <= '0;
      flush_cnt_q     <= '0;
      res_q           <= '0;
      core_input_text <= '0;
      core_key        <= '0;
      core_mod        <= '0;
    end else begin
      if (state_q == StFlush) flush_cnt_q <= flush_cnt_q + 2'd1;
      else                    flush_cnt_q <= '0;
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            sel_q           <= grant_idx;
            rr_ptr_q        <= grant_idx;
            core_input_text <= req_text[32'(grant_idx)*W +: W];
            core_key        <= req_key[32'(grant_idx)*W +: W];
            core_mod        <= req_mod[32'(grant_idx)*W +: W];
          end
        end
        StLaunch: begin
          wd_q    <= '0;
          armed_q <= 1'b0;
        end
        StWait: begin
          wd_q <= wd_q + TO_W'(1);
          // a done level left over from the previous operation is ignored until it drops
          if (!core_done) armed_q <= 1'b1;
          if (armed_q && core_done) res_q <= core_output_text;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack        = '0;
    rsp_valid  = '0;
    rsp_text   = '0;
    rsp_err    = 1'b0;
    busy       = 1'b0;
    core_go    = 1'b0;
    core_reset = reset;
    if (!reset) begin
      unique case (state_q)
        StIdle: ;
        StLaunch: begin
          busy       = 1'b1;
          ack[sel_q] = 1'b1;
          core_go    = 1'b1;
        end
        StWait: busy = 1'b1;
        StResp: begin
          busy             = 1'b1;
          rsp_valid[sel_q] = 1'b1;
          rsp_text         = res_q;
        end
        StFlush: begin
          busy = 1'b1;
          if (flush_cnt_q == 2'd2) begin
            rsp_valid[sel_q] = 1'b1;
            rsp_err          = 1'b1;
          end else begin
            core_reset = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// tb_rsa_core_arbiter: directed checks of grant order, handshake, stale done, watchdog flush
// and reset abort, using a behavioural modexp core model.
module tb_rsa_core_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req, ack, rsp_valid;
  logic [N*W-1:0] req_text, req_key, req_mod;
  logic [W-1:0]   rsp_text, core_input_text, core_key, core_mod, core_output_text;
  logic           rsp_err, busy, core_reset, core_go, core_done;

  logic [N-1:0]   wd_req, wd_ack, wd_rsp_valid;
  logic [N*W-1:0] wd_text, wd_key, wd_mod;
  logic [W-1:0]   wd_rsp_text, wd_ct, wd_ck, wd_cm, wd_out;
  logic           wd_rsp_err, wd_busy, wd_core_reset, wd_go, wd_done;

  int n_total = 0;
  int n_bad   = 0;

  rsa_core_arbiter #(.N_REQ(N), .W(W), .TO_W(20)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_text(req_text), .req_key(req_key),
    .req_mod(req_mod), .ack(ack), .rsp_valid(rsp_valid), .rsp_text(rsp_text),
    .rsp_err(rsp_err), .busy(busy), .core_reset(core_reset),
    .core_input_text(core_input_text), .core_key(core_key), .core_mod(core_mod),
    .core_go(core_go), .core_done(core_done), .core_output_text(core_output_text)
  );

  rsa_core_arbiter #(.N_REQ(N), .W(W), .TO_W(4)) u_dut_wd (
    .clk(clk), .reset(reset), .req(wd_req), .req_text(wd_text), .req_key(wd_key),
    .req_mod(wd_mod), .ack(wd_ack), .rsp_valid(wd_rsp_valid), .rsp_text(wd_rsp_text),
    .rsp_err(wd_rsp_err), .busy(wd_busy), .core_reset(wd_core_reset),
    .core_input_text(wd_ct), .core_key(wd_ck), .core_mod(wd_cm),
    .core_go(wd_go), .core_done(wd_done), .core_output_text(wd_out)
  );

  function automatic logic [W-1:0] modexp(input logic [W-1:0] t, k, m);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < int'(k); i++) r = (r * 64'(t)) % 64'(m);
    return r[W-1:0];
  endfunction

  function automatic logic [63:0] onehot(input int s);
    return 64'(1) << s;
  endfunction

  // Main core model: done is a level that stays high until the next go, optionally for
  // 'stale' extra cycles after it, and the result updates only on completion.
  int lat = 40;
  int stale = 0;
  int m_cnt, m_st;
  bit m_run;
  logic [W-1:0] m_t, m_k, m_m;
  always @(posedge clk) begin
    if (core_reset) begin
      core_done <= 1'b0; m_run <= 1'b0; core_output_text <= '0;
    end else if (core_go) begin
      m_run <= 1'b1; m_cnt <= lat; m_st <= stale;
      m_t <= core_input_text; m_k <= core_key; m_m <= core_mod;
      if (stale == 0) core_done <= 1'b0;
    end else if (m_run) begin
      if (m_st > 0) begin
        m_st <= m_st - 1;
        if (m_st == 1) core_done <= 1'b0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else begin
        core_done <= 1'b1; core_output_text <= modexp(m_t, m_k, m_m); m_run <= 1'b0;
      end
    end
  end

  // Watchdog-instance core model: completes after 5 cycles unless hung.
  bit wd_hang = 1'b0;
  int wd_cnt;
  always @(posedge clk) begin
    if (wd_core_reset) begin
      wd_done <= 1'b0; wd_cnt <= 0; wd_out <= '0;
    end else if (wd_go) begin
      wd_done <= 1'b0; wd_cnt <= wd_hang ? 0 : 5;
    end else if (wd_cnt == 1) begin
      wd_done <= 1'b1; wd_out <= modexp(wd_ct, wd_ck, wd_cm); wd_cnt <= 0;
    end else if (wd_cnt > 1) begin
      wd_cnt <= wd_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int s, input logic [W-1:0] t, k, m);
    req_text[s*W +: W] = t;
    req_key[s*W +: W]  = k;
    req_mod[s*W +: W]  = m;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Waits for ack of the expected slot, drops its req the next cycle, waits for the response.
  task automatic serve(input int slot, input logic [W-1:0] exp_text, input string tag,
                       output int ack_cyc, output int rsp_cyc);
    int gos;
    ack_cyc = 0;
    do begin @(negedge clk); ack_cyc++; end while (ack == '0 && ack_cyc < 100);
    check({tag, " ack"}, 64'(ack), onehot(slot));
    gos = int'(core_go);
    @(posedge clk); #1 req[slot] = 1'b0;
    rsp_cyc = 0;
    do begin
      @(negedge clk); rsp_cyc++; gos += int'(core_go);
    end while (rsp_valid == '0 && rsp_cyc < 400);
    check({tag, " rsp_valid"}, 64'(rsp_valid), onehot(slot));
    check({tag, " rsp_text"}, 64'(rsp_text), 64'(exp_text));
    check({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, " go count"}, 64'(gos), 64'd1);
  endtask

  initial begin
    int a, r, cnt, n;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] exp_txt[4] = '{32'd32, 32'd15, 32'd16, 32'd3};

    reset = 1'b1; req = '0; req_text = '0; req_key = '0; req_mod = '0;
    wd_req = '0; wd_text = '0; wd_key = '0; wd_mod = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst core_reset", 64'(core_reset), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle core_reset", 64'(core_reset), 64'd0);
    check("idle outputs", {ack, rsp_valid, busy, core_go}, 64'd0);
    check("idle operands", {core_input_text, core_key}, 64'd0);

    // 1: single request, 5^3 mod 33 = 26
    set_op(0, 32'd5, 32'd3, 32'd33);
    @(posedge clk); #1 req[0] = 1'b1;
    @(negedge clk);
    check("t1 ack same cycle", 64'(ack), 64'd0);
    serve(0, 32'd26, "t1", a, r);
    check("t1 ack latency", 64'(a), 64'd1);
    check("t1 rsp after lat", 64'(r >= 40), 64'd1);

    // 2: all four held; rotating grant order 0,1,2,3,0
    do_reset();
    set_op(0, 32'd2, 32'd5, 32'd33);
    set_op(1, 32'd3, 32'd4, 32'd33);
    set_op(2, 32'd4, 32'd2, 32'd33);
    set_op(3, 32'd6, 32'd2, 32'd33);
    lat = 12;
    @(posedge clk); #1 req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(order[i], exp_txt[order[i]], $sformatf("t2 txn%0d", i), a, r);
      if (i < 4) req[order[i]] = 1'b1;
      else       req = '0;
    end

    // 3: done still high from the previous op for 3 cycles after go
    stale = 3; lat = 10;
    set_op(0, 32'd5, 32'd3, 32'd33);
    @(posedge clk); #1 req[0] = 1'b1;
    serve(0, 32'd26, "t3", a, r);
    check("t3 no early rsp", 64'(r > 10), 64'd1);
    stale = 0;

    // 5: reset while in WAIT aborts silently
    lat = 40;
    set_op(2, 32'd4, 32'd2, 32'd33);
    @(posedge clk); #1 req[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == '0 && n < 100);
    check("t5 ack", 64'(ack), onehot(2));
    @(posedge clk); #1 req[2] = 1'b0;
    repeat (5) @(negedge clk);
    check("t5 busy in wait", 64'(busy), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t5 outputs after reset", {ack, rsp_valid, busy, core_go, core_reset}, 64'd0);
    check("t5 operands after reset", {core_input_text, core_mod}, 64'd0);
    cnt = 0;
    repeat (60) begin @(negedge clk); cnt += int'(rsp_valid != '0); end
    check("t5 no rsp after abort", 64'(cnt), 64'd0);
    set_op(3, 32'd6, 32'd2, 32'd33);
    @(posedge clk); #1 req[3] = 1'b1;
    serve(3, 32'd3, "t5 slot3", a, r);

    // 6: req[1] pulsed for one cycle while slot 2 wins (rr_ptr=1 after serving slot 1)
    lat = 8;
    set_op(1, 32'd3, 32'd4, 32'd33);
    @(posedge clk); #1 req[1] = 1'b1;
    serve(1, 32'd15, "t6 slot1", a, r);
    @(posedge clk); #1 req[1] = 1'b1; req[2] = 1'b1;
    @(posedge clk); #1 req[1] = 1'b0;
    serve(2, 32'd16, "t6 slot2", a, r);
    cnt = 0;
    repeat (50) begin @(negedge clk); cnt += int'(ack[1]); end
    check("t6 slot1 never acked", 64'(cnt), 64'd0);
    check("t6 idle", 64'(busy), 64'd0);

    // 4: TO_W=4 instance with a hung core
    wd_hang = 1'b1;
    wd_text[W +: W] = 32'd7; wd_key[W +: W] = 32'd2; wd_mod[W +: W] = 32'd33;
    @(posedge clk); #1 wd_req[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (wd_ack == '0 && n < 100);
    check("t4 ack", 64'(wd_ack), onehot(1));
    @(posedge clk); #1 wd_req[1] = 1'b0;
    n = 0; cnt = 0;
    do begin
      @(negedge clk); n++; cnt += int'(wd_core_reset);
    end while (wd_rsp_valid == '0 && n < 200);
    check("t4 core_reset cycles", 64'(cnt), 64'd2);
    check("t4 rsp_valid", 64'(wd_rsp_valid), onehot(1));
    check("t4 rsp_err", 64'(wd_rsp_err), 64'd1);
    check("t4 rsp_text", 64'(wd_rsp_text), 64'd0);
    check("t4 timeout window", 64'(n >= 16 && n <= 24), 64'd1);
    wd_hang = 1'b0;
    wd_text[0 +: W] = 32'd5; wd_key[0 +: W] = 32'd3; wd_mod[0 +: W] = 32'd33;
    @(posedge clk); #1 wd_req[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (wd_ack == '0 && n < 100);
    check("t4 recover ack", 64'(wd_ack), onehot(0));
    @(posedge clk); #1 wd_req[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (wd_rsp_valid == '0 && n < 200);
    check("t4 recover rsp_valid", 64'(wd_rsp_valid), onehot(0));
    check("t4 recover rsp_err", 64'(wd_rsp_err), 64'd0);
    check("t4 recover rsp_text", 64'(wd_rsp_text), 64'd26);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
